// File: rtl/ans_check.sv
// ans_check: latches a question, collects up to three factor codes and grades them as an unordered multiset.
module ans_check #(
  parameter int MAX_TRIES = 3,
  parameter int SCORE_MAX = 99
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [25:0] QUESTION,
  input  logic        LOAD,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  input  logic        DEL,
  input  logic        SUBMIT,
  output logic [11:0] ENTRY,
  output logic [1:0]  ENTRY_CNT,
  output logic        BUSY,
  output logic        RESULT_VALID,
  output logic        CORRECT,
  output logic        DONE,
  output logic [1:0]  TRIES,
  output logic [6:0]  SCORE
);
  typedef enum logic [1:0] {IDLE, ENTER, CHECK} state_t;
  state_t state, state_n;
  logic [1:0] diff, diff_n, cnt_n, tries_n;
  logic [11:0] ans, ans_n, entry_n;
  logic [6:0] score_n, score_inc;
  logic [7:0] score_sum;
  logic rv_n, correct_n, done_n, match;
  logic unused_bits;
  assign unused_bits = ^QUESTION[23:12];
  // Sorting both sides descending turns the multiset compare into plain equality; zeros land in the top slots.
  function automatic logic [11:0] sort3(input logic [11:0] v);
    logic [3:0] a, b, c, t;
    a = v[3:0];
    b = v[7:4];
    c = v[11:8];
    if (a < b) begin t = a; a = b; b = t; end
    if (b < c) begin t = b; b = c; c = t; end
    if (a < b) begin t = a; a = b; b = t; end
    return {c, b, a};
  endfunction
  always_comb begin
    match = sort3(ENTRY) == ans;
    score_sum = {1'b0, SCORE} + 8'(diff) + 8'd1;
    score_inc = score_sum > 8'(SCORE_MAX) ? 7'(SCORE_MAX) : score_sum[6:0];
    state_n = state;
    diff_n = diff;
    ans_n = ans;
    entry_n = ENTRY;
    cnt_n = ENTRY_CNT;
    tries_n = TRIES;
    score_n = SCORE;
    rv_n = 1'b0;
    done_n = 1'b0;
    correct_n = CORRECT;
    if (LOAD) begin
      diff_n = QUESTION[25:24];
      ans_n = sort3(QUESTION[11:0]);
      entry_n = '0;
      cnt_n = '0;
      tries_n = 2'(MAX_TRIES);
      state_n = ENTER;
    end else if (state == ENTER) begin
      if (SUBMIT) state_n = CHECK;
      else if (DEL) begin
        if (ENTRY_CNT != 2'd0) begin
          entry_n[{ENTRY_CNT - 2'd1, 2'b00} +: 4] = 4'd0;
          cnt_n = ENTRY_CNT - 2'd1;
        end
      end else if (KEY_VALID && KEY_CODE inside {[4'd1:4'd9]} && ENTRY_CNT != 2'd3) begin
        entry_n[{ENTRY_CNT, 2'b00} +: 4] = KEY_CODE;
        cnt_n = ENTRY_CNT + 2'd1;
      end
    end else if (state == CHECK) begin
      rv_n = 1'b1;
      correct_n = match;
      if (match) begin
        score_n = score_inc;
        done_n = 1'b1;
        state_n = IDLE;
      end else if (TRIES <= 2'd1) begin
        tries_n = 2'd0;
        done_n = 1'b1;
        state_n = IDLE;
      end else begin
        tries_n = TRIES - 2'd1;
        entry_n = '0;
        cnt_n = '0;
        state_n = ENTER;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      diff <= '0;
      ans <= '0;
      ENTRY <= '0;
      ENTRY_CNT <= '0;
      BUSY <= 1'b0;
      RESULT_VALID <= 1'b0;
      CORRECT <= 1'b0;
      DONE <= 1'b0;
      TRIES <= '0;
      SCORE <= '0;
    end else begin
      state <= state_n;
      diff <= diff_n;
      ans <= ans_n;
      ENTRY <= entry_n;
      ENTRY_CNT <= cnt_n;
      BUSY <= state_n != IDLE;
      RESULT_VALID <= rv_n;
      CORRECT <= correct_n;
      DONE <= done_n;
      TRIES <= tries_n;
      SCORE <= score_n;
    end
  end
endmodule
